// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, CHUNK bits per cycle.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing chunk instead of always running NCH cycles.
module serial_mag_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Handshake: start is accepted only while busy is low; operands are captured on that
    // edge, busy stays high through COMPARE and DONE, and done pulses for one cycle when
    // A_gt_B/A_lt_B/A_eq_B carry the new result (they hold until the next done).
    state_t state;
    state_t state_n;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    count;
    logic             decided;
    logic             gt_r;
    logic             lt_r;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic             ch_gt;
    logic             ch_lt;
    logic             gt_n;
    logic             lt_n;
    logic             last;
    logic             finish;

    assign a_ch  = a_sh[WIDTH-1 -: CHUNK];
    assign b_ch  = b_sh[WIDTH-1 -: CHUNK];
    assign ch_gt = !decided && (a_ch > b_ch);
    assign ch_lt = !decided && (a_ch < b_ch);
    assign gt_n  = gt_r | ch_gt;
    assign lt_n  = lt_r | ch_lt;
    assign last  = (count == CW'(1));

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign finish = last || ch_gt || ch_lt;
`else
    assign finish = last;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = COMPARE;
            COMPARE: if (finish) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Flipping the sign bit maps two's complement onto offset binary, so the chunk
    // compare below can stay purely unsigned.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            count   <= '0;
            decided <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            A_gt_B  <= 1'b0;
            A_lt_B  <= 1'b0;
            A_eq_B  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= A ^ {signed_mode, {(WIDTH-1){1'b0}}};
                        b_sh    <= B ^ {signed_mode, {(WIDTH-1){1'b0}}};
                        count   <= CW'(NCH);
                        decided <= 1'b0;
                        gt_r    <= 1'b0;
                        lt_r    <= 1'b0;
                    end
                end
                COMPARE: begin
                    a_sh  <= a_sh << CHUNK;
                    b_sh  <= b_sh << CHUNK;
                    count <= count - CW'(1);
                    if (ch_gt || ch_lt) begin
                        decided <= 1'b1;
                        gt_r    <= ch_gt;
                        lt_r    <= ch_lt;
                    end
                    if (finish) begin
                        A_gt_B <= gt_n;
                        A_lt_B <= lt_n;
                        A_eq_B <= !(gt_n || lt_n);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator (WIDTH=8, CHUNK=2) with a cycle-level reference
// model derived from the arithmetic result and the expected latency.
module tb_serial_mag_comparator;

    localparam int WIDTH = 8;
    localparam int CHUNK = 2;
    localparam int NCH   = WIDTH / CHUNK;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             signed_mode = 1'b0;
    logic             busy, done, A_gt_B, A_lt_B, A_eq_B;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic [2:0] exp_q[$];

    serial_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .signed_mode(signed_mode), .busy(busy), .done(done),
        .A_gt_B(A_gt_B), .A_lt_B(A_lt_B), .A_eq_B(A_eq_B)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: arithmetic result and latency
    function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sm);
        longint av, bv;
        if (sm) begin
            av = longint'($signed(a));
            bv = longint'($signed(b));
        end else begin
            av = longint'(a);
            bv = longint'(b);
        end
        return {av > bv, av < bv, av == bv};
    endfunction

    function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sm);
        logic [WIDTH-1:0] ao, bo;
        if (!EE) return NCH;
        ao = sm ? (a ^ 8'h80) : a;
        bo = sm ? (b ^ 8'h80) : b;
        for (int k = 1; k <= NCH; k++) begin
            if ((ao >> (WIDTH - k * CHUNK)) != (bo >> (WIDTH - k * CHUNK))) return k;
        end
        return NCH;
    endfunction

    int         m_left = 0;
    bit         m_done = 1'b0;
    bit         m_busy = 1'b0;
    logic [2:0] m_res  = 3'b000;
    logic [2:0] m_out  = 3'b000;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_out  = 3'b000;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_out  = m_res;
            end
        end else if (start) begin
            m_res  = ref_result(A, B, signed_mode);
            m_left = ref_lat(A, B, signed_mode);
        end
        m_busy = (m_left > 0) || m_done;
    end

    // scoreboard / compare process
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("gt", A_gt_B, m_out[2]);
            check("lt", A_lt_B, m_out[1]);
            check("eq", A_eq_B, m_out[0]);
            if (done) begin
                if (exp_q.size() == 0) check("unexpected_done", 1, 0);
                else check("result_vs_table", {A_gt_B, A_lt_B, A_eq_B}, exp_q.pop_front());
            end
        end
    end

    // driver: one operation; poke re-pulses start with other operands while busy
    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sm, input logic [2:0] exp_res, input int exp_lat,
                          input bit poke);
        int lat, nbusy;
        bit seen;
        @(negedge clk);
        A = a; B = b; signed_mode = sm; start = 1'b1;
        exp_q.push_back(exp_res);
        @(negedge clk);
        start = 1'b0;
        A = WIDTH'($urandom_range(0, 255));
        B = WIDTH'($urandom_range(0, 255));
        signed_mode = 1'($urandom_range(0, 1));
        lat = 0; nbusy = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            if (busy) nbusy++;
            if (poke && (lat == 1 || lat == 2)) begin
                start = 1'b1; A = 8'h00; B = 8'h7F; signed_mode = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (busy) nbusy++;
        check({name, "_timeout"}, seen, 1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_cycles"}, nbusy, exp_lat + 1);
    endtask

    initial begin
        @(posedge clk);
        cmp_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_outs", {A_gt_B, A_lt_B, A_eq_B}, 3'b000);

        run_op("eq_5a",       8'h5A, 8'h5A, 1'b0, R_EQ, 4,           1'b0);
        run_op("u_80_7f",     8'h80, 8'h7F, 1'b0, R_GT, EE ? 1 : 4,  1'b0);
        run_op("s_80_7f",     8'h80, 8'h7F, 1'b1, R_LT, EE ? 1 : 4,  1'b0);
        run_op("s_ff_00",     8'hFF, 8'h00, 1'b1, R_LT, EE ? 1 : 4,  1'b0);
        run_op("u_03_02",     8'h03, 8'h02, 1'b0, R_GT, 4,           1'b0);
        run_op("u_12_34",     8'h12, 8'h34, 1'b0, R_LT, EE ? 2 : 4,  1'b0);
        run_op("s_c0_c4",     8'hC0, 8'hC4, 1'b1, R_LT, EE ? 3 : 4,  1'b0);
        run_op("busy_ignore", 8'h03, 8'h02, 1'b0, R_GT, 4,           1'b1);

        // reset during the second COMPARE cycle aborts without a done pulse
        @(negedge clk);
        A = 8'h03; B = 8'h02; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_outs", {A_gt_B, A_lt_B, A_eq_B}, 3'b000);

        run_op("after_abort", 8'h7F, 8'h80, 1'b1, R_GT, EE ? 1 : 4, 1'b0);

        repeat (3) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
